// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard inputs in, stage hold/bubble/flush controls and counters out.
// The master modport is the pipeline side and the slave modport is the controller side.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             MemRead_ex;
  logic [4:0]       Rd_ex;
  logic [4:0]       Rs1_id;
  logic [4:0]       Rs2_id;
  logic             rs1_used_id;
  logic             rs2_used_id;
  logic             redirect_ex;
  logic             mem_access_mem;
  logic             dmem_ready;
  logic             pc_hold;
  logic             if_id_hold;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             id_ex_flush;
  logic             back_hold;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output MemRead_ex, Rd_ex, Rs1_id, Rs2_id, rs1_used_id, rs2_used_id,
           redirect_ex, mem_access_mem, dmem_ready,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_bubble, id_ex_flush,
           back_hold, mem_timeout_err, stall_cycles, flush_events
  );

  modport slave (
    input  MemRead_ex, Rd_ex, Rs1_id, Rs2_id, rs1_used_id, rs2_used_id,
           redirect_ex, mem_access_mem, dmem_ready,
    output pc_hold, if_id_hold, if_id_flush, id_ex_bubble, id_ex_flush,
           back_hold, mem_timeout_err, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubble, EX redirect flush, data-memory freeze; zero-latency controls.
// Backpressure comes from dmem_ready: a pending access freezes the whole pipe, with a memory-wait watchdog and saturating counters.
module hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [15:0]      TIMEOUT_V = TIMEOUT[15:0];
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_wait_cnt;
  logic [15:0]      w_wait_inc;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  logic w_freeze;
  logic w_load_use;
  logic w_pc_hold;
  logic w_if_id_hold;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_id_ex_flush;
  logic w_back_hold;

  assign w_load_use = hz.MemRead_ex && (hz.Rd_ex != 5'd0) &&
                      ((hz.rs1_used_id && (hz.Rs1_id == hz.Rd_ex)) ||
                       (hz.rs2_used_id && (hz.Rs2_id == hz.Rd_ex)));

  always_comb begin
    w_next         = r_state;
    w_freeze       = 1'b0;
    w_pc_hold      = 1'b0;
    w_if_id_hold   = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_back_hold    = 1'b0;

    case (r_state)
      RUN: begin
        if (hz.mem_access_mem && !hz.dmem_ready) begin
          w_freeze = 1'b1;
          w_next   = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          w_next = RUN;
        end else begin
          w_freeze = 1'b1;
        end
      end
      default: w_next = RUN;
    endcase

    // A frozen EX keeps redirect/load_use alive, so they are serviced on release.
    if (w_freeze) begin
      w_pc_hold    = 1'b1;
      w_if_id_hold = 1'b1;
      w_back_hold  = 1'b1;
    end else if (hz.redirect_ex) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      w_pc_hold      = 1'b1;
      w_if_id_hold   = 1'b1;
      w_id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_wait_inc = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= 16'd0;
      r_timeout_err <= 1'b0;
    end else if (r_state == RUN) begin
      r_wait_cnt <= 16'd0;
    end else if (!hz.dmem_ready) begin
      r_wait_cnt <= w_wait_inc;
      if (w_wait_inc >= TIMEOUT_V) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_pc_hold && (r_stall_cycles != CNT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
      end
      if (w_if_id_flush && (r_flush_events != CNT_MAX)) begin
        r_flush_events <= r_flush_events + CNT_ONE;
      end
    end
  end

  assign hz.pc_hold         = w_pc_hold;
  assign hz.if_id_hold      = w_if_id_hold;
  assign hz.if_id_flush     = w_if_id_flush;
  assign hz.id_ex_bubble    = w_id_ex_bubble;
  assign hz.id_ex_flush     = w_id_ex_flush;
  assign hz.back_hold       = w_back_hold;
  assign hz.mem_timeout_err = r_timeout_err;
  assign hz.stall_cycles    = r_stall_cycles;
  assign hz.flush_events    = r_flush_events;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with CNT_W=4, TIMEOUT=4: the driver queues hand-computed expectations per cycle,
// and a monitor compares them at the falling edge. Control bits are {pc_hold,if_id_hold,if_id_flush,id_ex_bubble,id_ex_flush,back_hold}.
module tb_hazard_ctrl;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] LU   = 6'b110100;
  localparam logic [5:0] RD   = 6'b001010;
  localparam logic [5:0] FRZ  = 6'b110001;

  typedef struct {
    logic [5:0] ctrl;
    logic       err;
    logic [3:0] stall;
    logic [3:0] flush;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  hazard_ctrl_if #(.CNT_W(4)) hz ();

  hazard_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic rdr, input logic ma, input logic rdy);
    hz.MemRead_ex     = mr;
    hz.Rd_ex          = rd;
    hz.Rs1_id         = r1;
    hz.Rs2_id         = r2;
    hz.rs1_used_id    = u1;
    hz.rs2_used_id    = u2;
    hz.redirect_ex    = rdr;
    hz.mem_access_mem = ma;
    hz.dmem_ready     = rdy;
  endtask

  task automatic expect_now(input logic [5:0] ec, input logic ee, input logic [3:0] es,
                            input logic [3:0] ef, input string nm);
    exp_t e;
    e.ctrl = ec; e.err = ee; e.stall = es; e.flush = ef; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic rdr, input logic ma, input logic rdy,
                     input logic [5:0] ec, input logic ee, input logic [3:0] es, input logic [3:0] ef,
                     input string nm);
    @(posedge clk);
    #1;
    drive(mr, rd, r1, r2, u1, u2, rdr, ma, rdy);
    expect_now(ec, ee, es, ef, nm);
  endtask

  // Reset asserted between edges and checked before any rising edge; idle inputs expose a RUN state.
  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    expect_now(NONE, 1'b0, 4'd0, 4'd0, nm);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {hz.pc_hold, hz.if_id_hold, hz.if_id_flush, hz.id_ex_bubble, hz.id_ex_flush, hz.back_hold};
        n_tests++;
        if (act !== e.ctrl || hz.mem_timeout_err !== e.err ||
            hz.stall_cycles !== e.stall || hz.flush_events !== e.flush) begin
          n_fail++;
          $display("FAIL %s: got ctrl=%b err=%b stall=%0d flush=%0d, want ctrl=%b err=%b stall=%0d flush=%0d",
                   e.name, act, hz.mem_timeout_err, hz.stall_cycles, hz.flush_events,
                   e.ctrl, e.err, e.stall, e.flush);
        end
      end
    end
  end

  initial begin : driver
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("reset_state");

    //  mr rd r1 r2 u1 u2 rdr ma rdy   ctrl  err stall flush
    cyc(1, 5, 0, 5, 0, 1, 0, 0, 0,   LU,   0, 0, 0, "lu_rs2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   NONE, 0, 1, 0, "lu_one_bubble");
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 0,   NONE, 0, 1, 0, "lu_rd_zero");
    cyc(1, 7, 7, 3, 1, 1, 0, 0, 0,   LU,   0, 1, 0, "lu_rs1");
    cyc(1, 7, 7, 0, 0, 0, 0, 0, 0,   NONE, 0, 2, 0, "lu_rs1_unused");
    cyc(0, 7, 7, 0, 1, 0, 0, 0, 0,   NONE, 0, 2, 0, "lu_not_load");
    cyc(1, 5, 0, 5, 0, 1, 1, 0, 0,   RD,   0, 2, 0, "redir_over_lu");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   NONE, 0, 2, 1, "redir_counted");

    do_reset("reset_before_memwait");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0,   FRZ,  0, 0, 0, "mw_freeze1");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0,   FRZ,  0, 1, 0, "mw_freeze2");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0,   FRZ,  0, 2, 0, "mw_freeze3");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1,   NONE, 0, 3, 0, "mw_release");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   NONE, 0, 3, 0, "mw_back_in_run");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1,   NONE, 0, 3, 0, "mw_first_cycle_done");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   NONE, 0, 3, 0, "mw_no_state_change");
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0,   FRZ,  0, 3, 0, "mw_redir_frozen1");
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0,   FRZ,  0, 4, 0, "mw_redir_frozen2");
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 1,   RD,   0, 5, 0, "mw_redir_on_release");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   NONE, 0, 5, 1, "mw_redir_counted");
    cyc(1, 5, 0, 5, 0, 1, 0, 1, 0,   FRZ,  0, 5, 1, "mw_lu_frozen");
    cyc(1, 5, 0, 5, 0, 1, 0, 1, 1,   LU,   0, 6, 1, "mw_lu_on_release");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   NONE, 0, 7, 1, "mw_lu_counted");

    // Error is set on the edge where the MEM_WAIT wait count reaches 4 (end of the 5th frozen cycle).
    do_reset("reset_before_watchdog");
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, (i >= 5), 4'(i), 0, $sformatf("wd_wait%0d", i));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1,   NONE, 1, 10, 0, "wd_release_sticky");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   NONE, 1, 10, 0, "wd_idle_sticky");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0,   FRZ,  1, 10, 0, "ar_enter_wait");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0,   FRZ,  1, 11, 0, "ar_in_wait");
    do_reset("async_reset_mid_wait");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   NONE, 0, 0, 0, "ar_run_after_reset");

    do_reset("reset_before_sat");
    for (int i = 0; i < 20; i++) begin
      cyc(1, 9, 9, 0, 1, 0, 0, 0, 0, LU, 0, (i > 15) ? 4'd15 : 4'(i), 0, $sformatf("sat_stall%0d", i));
    end
    for (int i = 0; i < 18; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, RD, 0, 15, (i > 15) ? 4'd15 : 4'(i), $sformatf("sat_flush%0d", i));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   NONE, 0, 15, 15, "sat_hold");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
